// File: rtl/even_run_monitor.sv
// even_run_monitor
//   Watches the registered parity flag from the even/odd classifier and keeps
//   saturating even/odd sample counts plus the length of the current
//   same-parity run. Pulses streak_hit when an even run first reaches RUN_LEN
//   and sets a sticky alarm at the same time.
//
// Parameters
//   CNT_W   width of even_count, odd_count and run_len (saturate at 2^CNT_W-1)
//   RUN_LEN even-run length that fires streak_hit (1 .. 2^CNT_W-1)
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   sample_valid isEven carries a new sample this cycle
//   isEven       parity of the sample (1 = even)
//   clear        synchronous clear of counts, run and alarm (drops any sample)
//   even_count   saturating count of accepted even samples
//   odd_count    saturating count of accepted odd samples
//   run_len      saturating length of the current same-parity run
//   run_is_even  current run is even
//   streak_hit   one-cycle pulse when an even run first reaches RUN_LEN
//   alarm        sticky flag, set with streak_hit
module even_run_monitor #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned RUN_LEN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic             isEven,
    input  logic             clear,
    output logic [CNT_W-1:0] even_count,
    output logic [CNT_W-1:0] odd_count,
    output logic [CNT_W-1:0] run_len,
    output logic             run_is_even,
    output logic             streak_hit,
    output logic             alarm
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EVEN_RUN = 2'd1,
        ODD_RUN  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

    state_t           r_state;
    logic [CNT_W-1:0] r_even_cnt;
    logic [CNT_W-1:0] r_odd_cnt;
    logic [CNT_W-1:0] r_run_len;
    logic             r_streak_hit;
    logic             r_alarm;

    state_t           w_state_nxt;
    logic [CNT_W-1:0] w_even_nxt;
    logic [CNT_W-1:0] w_odd_nxt;
    logic [CNT_W-1:0] w_run_nxt;
    logic             w_hit_nxt;
    logic             w_alarm_nxt;
    logic             w_at_target;

    // True when the run already sits at RUN_LEN in EVEN_RUN; a saturated run
    // that stays at RUN_LEN must not fire again.
    assign w_at_target = (r_state == EVEN_RUN) && (r_run_len == RUN_LEN_C);

    always_comb begin
        w_state_nxt = r_state;
        w_even_nxt  = r_even_cnt;
        w_odd_nxt   = r_odd_cnt;
        w_run_nxt   = r_run_len;
        w_hit_nxt   = 1'b0;
        w_alarm_nxt = r_alarm;

        if (clear) begin
            w_state_nxt = IDLE;
            w_even_nxt  = '0;
            w_odd_nxt   = '0;
            w_run_nxt   = '0;
            w_alarm_nxt = 1'b0;
        end else if (sample_valid) begin
            if (isEven) begin
                w_even_nxt = (r_even_cnt == '1) ? r_even_cnt : r_even_cnt + ONE;
            end else begin
                w_odd_nxt = (r_odd_cnt == '1) ? r_odd_cnt : r_odd_cnt + ONE;
            end

            case (r_state)
                IDLE: begin
                    w_state_nxt = isEven ? EVEN_RUN : ODD_RUN;
                    w_run_nxt   = ONE;
                end
                EVEN_RUN: begin
                    if (isEven) begin
                        w_run_nxt = (r_run_len == '1) ? r_run_len : r_run_len + ONE;
                    end else begin
                        w_state_nxt = ODD_RUN;
                        w_run_nxt   = ONE;
                    end
                end
                ODD_RUN: begin
                    if (!isEven) begin
                        w_run_nxt = (r_run_len == '1) ? r_run_len : r_run_len + ONE;
                    end else begin
                        w_state_nxt = EVEN_RUN;
                        w_run_nxt   = ONE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_run_nxt   = '0;
                end
            endcase

            if ((w_state_nxt == EVEN_RUN) && (w_run_nxt == RUN_LEN_C) && !w_at_target) begin
                w_hit_nxt   = 1'b1;
                w_alarm_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_even_cnt   <= '0;
            r_odd_cnt    <= '0;
            r_run_len    <= '0;
            r_streak_hit <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_even_cnt   <= w_even_nxt;
            r_odd_cnt    <= w_odd_nxt;
            r_run_len    <= w_run_nxt;
            r_streak_hit <= w_hit_nxt;
            r_alarm      <= w_alarm_nxt;
        end
    end

    assign even_count  = r_even_cnt;
    assign odd_count   = r_odd_cnt;
    assign run_len     = r_run_len;
    assign run_is_even = (r_state == EVEN_RUN);
    assign streak_hit  = r_streak_hit;
    assign alarm       = r_alarm;

endmodule

// File: tb/tb_even_run_monitor.sv
module tb_even_run_monitor;

    localparam int unsigned RL = 4;

    typedef struct {
        logic [7:0] ev;
        logic [7:0] od;
        logic [7:0] run;
        logic       re;
        logic       hit;
        logic       al;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, sv, ie, clr;
    logic [7:0] ec, oc, rl;
    logic       rie, sh, al;

    logic       rst3, sv3, ie3, clr3;
    logic [2:0] ec3, oc3, rl3;
    logic       rie3, sh3, al3;

    int errors = 0;
    int checks = 0;
    int hit_cnt = 0;
    exp_t q[$];

    // reference model state (8-bit instance)
    int         m_st;   // 0 idle, 1 even run, 2 odd run
    logic [7:0] m_ev, m_od, m_run;
    logic       m_al;

    always #5 clk = ~clk;

    even_run_monitor #(.CNT_W(8), .RUN_LEN(RL)) dut (
        .clk(clk), .reset(rst_n), .sample_valid(sv), .isEven(ie), .clear(clr),
        .even_count(ec), .odd_count(oc), .run_len(rl),
        .run_is_even(rie), .streak_hit(sh), .alarm(al)
    );

    even_run_monitor #(.CNT_W(3), .RUN_LEN(RL)) dut3 (
        .clk(clk), .reset(rst3), .sample_valid(sv3), .isEven(ie3), .clear(clr3),
        .even_count(ec3), .odd_count(oc3), .run_len(rl3),
        .run_is_even(rie3), .streak_hit(sh3), .alarm(al3)
    );

    // Scoreboard: every driven cycle pushes its expected outputs; they are
    // compared just after the edge that registers them.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sh === 1'b1) hit_cnt++;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (ec !== e.ev) begin errors++; $display("FAIL sb_even_count got=%0d exp=%0d t=%0t", ec, e.ev, $time); end
            checks++;
            if (oc !== e.od) begin errors++; $display("FAIL sb_odd_count got=%0d exp=%0d t=%0t", oc, e.od, $time); end
            checks++;
            if (rl !== e.run) begin errors++; $display("FAIL sb_run_len got=%0d exp=%0d t=%0t", rl, e.run, $time); end
            checks++;
            if (rie !== e.re) begin errors++; $display("FAIL sb_run_is_even got=%b exp=%b t=%0t", rie, e.re, $time); end
            checks++;
            if (sh !== e.hit) begin errors++; $display("FAIL sb_streak_hit got=%b exp=%b t=%0t", sh, e.hit, $time); end
            checks++;
            if (al !== e.al) begin errors++; $display("FAIL sb_alarm got=%b exp=%b t=%0t", al, e.al, $time); end
        end
    end

    task automatic model_reset();
        m_st = 0; m_ev = '0; m_od = '0; m_run = '0; m_al = 1'b0;
    endtask

    // Drive one cycle of stimulus at the falling edge and push the expectation.
    task automatic drive(input logic v, input logic e, input logic c);
        exp_t x;
        int   old_st;
        logic [7:0] old_run;
        @(negedge clk);
        sv = v; ie = e; clr = c;
        old_st = m_st; old_run = m_run;
        x.hit = 1'b0;
        if (c) begin
            model_reset();
        end else if (v) begin
            if (e) begin if (m_ev != 8'hFF) m_ev++; end
            else   begin if (m_od != 8'hFF) m_od++; end
            if (m_st == (e ? 1 : 2)) begin
                if (m_run != 8'hFF) m_run++;
            end else begin
                m_st  = e ? 1 : 2;
                m_run = 8'd1;
            end
            if (m_st == 1 && m_run == 8'(RL) && !(old_st == 1 && old_run == 8'(RL))) begin
                x.hit = 1'b1;
                m_al  = 1'b1;
            end
        end
        x.ev = m_ev; x.od = m_od; x.run = m_run; x.re = (m_st == 1); x.al = m_al;
        q.push_back(x);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sv = 1'b0; ie = 1'b1; clr = 1'b0;
        rst3 = 1'b0; sv3 = 1'b0; ie3 = 1'b1; clr3 = 1'b0;
        #3;
        checks++;
        if ({ec, oc, rl, rie, sh, al} !== '0) begin
            errors++; $display("FAIL reset_state got=%h exp=0", {ec, oc, rl, rie, sh, al});
        end
        checks++;
        if ({ec3, oc3, rl3, rie3, sh3, al3} !== '0) begin
            errors++; $display("FAIL reset_state_w3 got=%h exp=0", {ec3, oc3, rl3, rie3, sh3, al3});
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1; rst3 = 1'b1;
    endtask

    task automatic test_streak();
        repeat (3) drive(1'b1, 1'b1, 1'b0);
        settle();
        checks++; if (ec !== 8'd3)  begin errors++; $display("FAIL streak_even3 got=%0d exp=3", ec); end
        checks++; if (rl !== 8'd3)  begin errors++; $display("FAIL streak_run3 got=%0d exp=3", rl); end
        checks++; if (rie !== 1'b1) begin errors++; $display("FAIL streak_is_even got=%b exp=1", rie); end
        checks++; if (al !== 1'b0 || hit_cnt !== 0) begin
            errors++; $display("FAIL streak_early alarm=%b hits=%0d exp alarm=0 hits=0", al, hit_cnt);
        end
        drive(1'b1, 1'b1, 1'b0);
        settle();
        checks++; if (sh !== 1'b1 || rl !== 8'd4) begin
            errors++; $display("FAIL streak_fire hit=%b run=%0d exp hit=1 run=4", sh, rl);
        end
        checks++; if (al !== 1'b1) begin errors++; $display("FAIL streak_alarm got=%b exp=1", al); end
        repeat (2) drive(1'b1, 1'b1, 1'b0);
        settle();
        checks++; if (rl !== 8'd6 || al !== 1'b1 || hit_cnt !== 1) begin
            errors++; $display("FAIL streak_after run=%0d alarm=%b hits=%0d exp run=6 alarm=1 hits=1", rl, al, hit_cnt);
        end
    endtask

    task automatic test_parity_change();
        int h0;
        drive(1'b0, 1'b0, 1'b1);
        settle();
        h0 = hit_cnt;
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        settle();
        checks++; if (rie !== 1'b0 || rl !== 8'd1 || oc !== 8'd1) begin
            errors++; $display("FAIL parity_odd is_even=%b run=%0d odd=%0d exp 0/1/1", rie, rl, oc);
        end
        repeat (3) drive(1'b1, 1'b1, 1'b0);
        settle();
        checks++; if (hit_cnt !== h0) begin errors++; $display("FAIL parity_nofire hits=%0d exp=%0d", hit_cnt, h0); end
        drive(1'b1, 1'b1, 1'b0);
        settle();
        checks++; if (sh !== 1'b1 || hit_cnt !== h0 + 1) begin
            errors++; $display("FAIL parity_fire7 hit=%b hits=%0d exp hit=1 hits=%0d", sh, hit_cnt, h0 + 1);
        end
        checks++; if (ec !== 8'd6 || oc !== 8'd1) begin
            errors++; $display("FAIL parity_counts even=%0d odd=%0d exp 6/1", ec, oc);
        end
    endtask

    task automatic test_gap();
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        repeat (5) drive(1'b0, 1'b1, 1'b0);
        settle();
        checks++; if (rl !== 8'd2 || ec !== 8'd2 || rie !== 1'b1) begin
            errors++; $display("FAIL gap_hold run=%0d even=%0d is_even=%b exp 2/2/1", rl, ec, rie);
        end
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        settle();
        checks++; if (sh !== 1'b1 || rl !== 8'd4) begin
            errors++; $display("FAIL gap_fire hit=%b run=%0d exp hit=1 run=4", sh, rl);
        end
    endtask

    task automatic test_clear_sample();
        drive(1'b1, 1'b1, 1'b1);
        settle();
        checks++; if ({ec, oc, rl, rie, sh, al} !== '0) begin
            errors++; $display("FAIL clear_all got=%h exp=0", {ec, oc, rl, rie, sh, al});
        end
        drive(1'b1, 1'b0, 1'b0);
        settle();
        checks++; if (ec !== 8'd0 || oc !== 8'd1 || rl !== 8'd1) begin
            errors++; $display("FAIL clear_restart even=%0d odd=%0d run=%0d exp 0/1/1", ec, oc, rl);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                  1'($urandom_range(0, 60) == 0));
        end
        drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_saturation();
        @(negedge clk);
        sv3 = 1'b1; ie3 = 1'b1; clr3 = 1'b0;
        repeat (9) @(negedge clk);
        checks++; if (ec3 !== 3'd7 || rl3 !== 3'd7 || rie3 !== 1'b1 || al3 !== 1'b1) begin
            errors++; $display("FAIL sat_even even=%0d run=%0d is_even=%b alarm=%b exp 7/7/1/1", ec3, rl3, rie3, al3);
        end
        ie3 = 1'b0;
        @(negedge clk);
        sv3 = 1'b0;
        checks++; if (oc3 !== 3'd1 || rl3 !== 3'd1 || rie3 !== 1'b0 || ec3 !== 3'd7) begin
            errors++; $display("FAIL sat_odd odd=%0d run=%0d is_even=%b even=%0d exp 1/1/0/7", oc3, rl3, rie3, ec3);
        end
        #2;
        rst3 = 1'b0;
        #1;
        checks++; if ({ec3, oc3, rl3, rie3, sh3, al3} !== '0) begin
            errors++; $display("FAIL sat_async_reset got=%h exp=0", {ec3, oc3, rl3, rie3, sh3, al3});
        end
        @(negedge clk);
        rst3 = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_streak();
        test_parity_change();
        test_gap();
        test_clear_sample();
        test_random();
        test_saturation();
        settle();
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL sb_drain left=%0d exp=0", q.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/even_run_monitor.md
Name: even_run_monitor

Overview:
- Consumes the registered isEven flag from the even/odd classifier FSM, one sample per cycle when sample_valid=1.
- Keeps saturating even and odd sample counts and tracks the current same-parity run.
- Pulses streak_hit when an even run reaches RUN_LEN. Sets a sticky alarm that software or the top level clears.

Parameters:
- CNT_W, 8, width of even_count, odd_count and run_len. Counters saturate at 2^CNT_W-1.
- RUN_LEN, 4, even-run length that triggers streak_hit. Legal range 1 to 2^CNT_W-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset. 0 forces the reset state immediately; release is synchronous to clk.
- sample_valid  input  1  1 = isEven carries a new sample this cycle.
- isEven  input  1  parity of the current sample (1 = even, 0 = odd).
- clear  input  1  synchronous clear of all counters, the run and alarm.
- even_count  output  CNT_W  number of even samples accepted, saturating.
- odd_count  output  CNT_W  number of odd samples accepted, saturating.
- run_len  output  CNT_W  length of the current same-parity run, saturating.
- run_is_even  output  1  1 when the current run is even (state EVEN_RUN).
- streak_hit  output  1  one-cycle pulse when an even run first reaches RUN_LEN.
- alarm  output  1  sticky; set together with streak_hit.

Behaviour:
- All outputs are registered. A sample accepted at edge N is reflected on the outputs after edge N (latency 1).
- Reset (reset=0, asynchronous):
  - state = IDLE.
  - even_count = 0, odd_count = 0, run_len = 0.
  - run_is_even = 0, streak_hit = 0, alarm = 0.
- FSM states: IDLE, EVEN_RUN, ODD_RUN. run_is_even = (state == EVEN_RUN).
- Priority at each edge: clear, then sample_valid, then hold.
- clear=1:
  - state becomes IDLE; counts, run_len and alarm go to 0; streak_hit = 0.
  - A sample presented in the same cycle is dropped and not counted.
- sample_valid=1, clear=0:
  - isEven=1: even_count += 1, saturating.
  - isEven=0: odd_count += 1, saturating.
  - IDLE: go to EVEN_RUN if isEven=1, else ODD_RUN. run_len = 1.
  - EVEN_RUN with isEven=1, or ODD_RUN with isEven=0: stay; run_len += 1, saturating at 2^CNT_W-1.
  - Parity change: switch to the other run state; run_len = 1.
- streak_hit = 1 for exactly one cycle when the next state is EVEN_RUN and next run_len == RUN_LEN.
  - Covers RUN_LEN=1: the first even sample after IDLE or after an odd run fires.
  - Saturated or longer runs never re-fire; a new pulse needs a new even run.
  - Otherwise streak_hit = 0.
- alarm is set in the same cycle as streak_hit and stays 1 until clear or reset. Further hits while set leave it at 1.
- sample_valid=0, clear=0:
  - All state and counts hold; streak_hit = 0.
  - A run is not broken by idle cycles.
- Saturation: a counter at 2^CNT_W-1 holds. The other counter and the FSM keep operating normally.
- Reset asserted mid-run: everything returns to reset values at once. The first sample after release starts from IDLE.
- isEven is ignored when sample_valid=0, including the value 1 the classifier drives during its own reset.

Test Plan:
- Reset then 3 valid even samples, RUN_LEN=4:
  - even_count = 3, run_len = 3, run_is_even = 1.
  - streak_hit never 1, alarm = 0.
- Continuing from the previous scenario, one more even, then 2 more evens:
  - streak_hit high exactly one cycle, with run_len = 4.
  - alarm = 1 and stays 1.
  - run_len ends at 6, no further pulse.
- Sequence E,E,O,E,E,E,E with valid=1 every cycle:
  - odd_count = 1, even_count = 6.
  - run resets to 1 at the odd sample; ODD_RUN for one cycle.
  - streak_hit fires on the 7th sample only.
- E,E, then valid=0 for 5 cycles, then E,E:
  - run_len holds at 2 during the gap.
  - streak_hit fires on the final sample (run_len = 4).
- clear=1 asserted together with sample_valid=1 and isEven=1:
  - All counts, run_len and alarm = 0; state IDLE.
  - The sample is not counted.
- CNT_W=3, 9 even samples:
  - even_count and run_len saturate at 7.
  - Then 1 odd sample: odd_count = 1, run_len = 1, run_is_even = 0.
  - Then reset pulse low mid-cycle: all outputs 0 immediately, before the next clk edge.
